pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, legal 1..3: cycles of IF/ID flush per redirect.
REQ-002 Parameter LU_BUBBLES, default 1, legal 1..2: bubbles inserted per load-use hazard.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 id_rs1, id_rs2  in  5 each  ID-stage source register numbers.
REQ-007 id_rs1_re, id_rs2_re  in  1 each  ID instruction reads rs1 / rs2.
REQ-008 ex_rd  in  5  EX-stage destination register.
REQ-009 ex_is_load  in  1  EX instruction is a load (write-data select = DRAM).
REQ-010 ex_redirect  in  1  EX resolved a taken branch, jal or jalr.
REQ-011 mem_req, mem_ack  in  1 each  MEM-stage DRAM access request and completion.
REQ-012 cnt_clr  in  1  clear performance counters.
REQ-013 pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold the PC / stage register.
REQ-014 ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble into the stage register.
REQ-015 redirect  out  1  PC loads the EX target this cycle.
REQ-016 stall_cnt, flush_cnt  out  16 each  performance counters.
REQ-017 state  out  2  current FSM state: RUN=0, LU_STALL=1, MEM_WAIT=2, FLUSH=3.

Function
REQ-018 The stage-control outputs SHALL be combinational from state, count and inputs; every output not asserted by a rule below SHALL be 0.
REQ-019 A hazard SHALL exist when ex_is_load=1, ex_rd!=0, and (id_rs1_re && id_rs1==ex_rd) or (id_rs2_re && id_rs2==ex_rd).
REQ-020 Mem stall condition: mem_req=1 and mem_ack=0. In RUN, LU_STALL or FLUSH it SHALL take priority over all other rules.
REQ-021 On a mem stall, the block SHALL assert pc_stall, ifid_stall, idex_stall, exmem_stall and memwb_flush, save the current state and count, and go to MEM_WAIT.
REQ-022 In MEM_WAIT the block SHALL assert the same five outputs while mem_ack=0.
REQ-023 In MEM_WAIT, in the cycle mem_ack=1, all stalls SHALL be deasserted and the saved state and count SHALL be restored. The count is frozen while waiting.
REQ-024 In MEM_WAIT the block SHALL ignore ex_redirect and hazards, because EX is held and they are resampled after the wait.
REQ-025 mem_req=1 with mem_ack=1 in the same cycle SHALL cause no stall.
REQ-026 In RUN, ex_redirect=1 SHALL assert redirect, ifid_flush and idex_flush, and SHALL take priority over a simultaneous hazard.
REQ-027 After a redirect, if FLUSH_CYCLES>1 the block SHALL enter FLUSH with count=FLUSH_CYCLES-1.
REQ-028 In FLUSH the block SHALL assert ifid_flush only and decrement count, returning to RUN when count reaches 1. Hazards are ignored in FLUSH.
REQ-029 In RUN, a hazard with no redirect and no mem stall SHALL assert pc_stall, ifid_stall and idex_flush.
REQ-030 After a hazard, if LU_BUBBLES=2 the block SHALL enter LU_STALL with count=1.
REQ-031 In LU_STALL the block SHALL assert the same three outputs for one cycle, then return to RUN.
REQ-032 count SHALL be a 2-bit register and SHALL never wrap below 0.
REQ-033 stall_cnt SHALL increment by 1 on each cycle with pc_stall=1.
REQ-034 flush_cnt SHALL increment by 1 on each cycle with redirect=1.
REQ-035 Both counters SHALL saturate at 0xFFFF; cnt_clr=1 SHALL zero both counters and SHALL override any increment in that cycle.

Reset
REQ-036 With rst=1 at a clock edge: state=RUN, count=0, saved state=RUN, stall_cnt=0, flush_cnt=0.
REQ-037 While rst=1, all stall, flush and redirect outputs SHALL be 0.
REQ-038 Reset SHALL abort MEM_WAIT, FLUSH or LU_STALL immediately, with no restore.

Verification
REQ-039 Load-use, LU_BUBBLES=1: ex_is_load=1, ex_rd=5, id_rs2=5, id_rs2_re=1 -> pc_stall=ifid_stall=idex_flush=1 for exactly 1 cycle; stall_cnt=1.
REQ-040 ex_rd=0 load with id_rs1=0, id_rs1_re=1 -> no stall. The same case with id_rs1_re=0 and a matching register -> no stall.
REQ-041 Redirect, FLUSH_CYCLES=2: ex_redirect=1 -> cycle 0: redirect=ifid_flush=idex_flush=1; cycle 1: ifid_flush only, state=3; cycle 2: state=0; flush_cnt=1.
REQ-042 Simultaneous ex_redirect=1, hazard, and mem_req=1/mem_ack=0 held for 3 cycles -> 3 cycles of MEM_WAIT stalls with redirect=0; on the ack cycle no stall; next cycle, with ex_redirect still 1 -> redirect=1.
REQ-043 LU_BUBBLES=2: hazard, then mem stall during LU_STALL lasting 2 cycles -> LU_STALL restored after the ack, then 1 more bubble cycle; stall_cnt=4.
REQ-044 Force stall_cnt to 0xFFFE, stall 3 cycles -> reads 0xFFFF. cnt_clr=1 during a stall -> 0. rst=1 mid-FLUSH -> state=0 at the next edge.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard, redirect and memory-wait controller for a 5-stage pipeline.
// Produces stall/flush/redirect strobes for the stage registers, tracks the
// multi-cycle flush and load-use bubble sequences, and keeps two saturating
// performance counters (stall cycles and redirects).
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int LU_BUBBLES   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_re,
  input  logic        id_rs2_re,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        cnt_clr,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        exmem_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_flush,
  output logic        redirect,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  // Count loaded on entering FLUSH; one flush cycle is the redirect cycle itself.
  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  state_t     cur_state;
  state_t     saved_state;
  logic [1:0] count;
  logic [1:0] saved_count;
  logic       mem_stall;
  logic       hazard;

  assign mem_stall = mem_req && !mem_ack;
  assign hazard    = ex_is_load && (ex_rd != 5'd0) &&
                     ((id_rs1_re && (id_rs1 == ex_rd)) ||
                      (id_rs2_re && (id_rs2 == ex_rd)));
  assign state     = cur_state;

  // Stage-control strobes decoded from the current state and this cycle's inputs.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    redirect    = 1'b0;
    if (!rst) begin
      case (cur_state)
        MEM_WAIT: begin
          if (!mem_ack) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
          end
        end
        default: begin
          if (mem_stall) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
          end else if (cur_state == FLUSH) begin
            ifid_flush = 1'b1;
          end else if (cur_state == LU_STALL) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end else if (ex_redirect) begin
            redirect   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (hazard) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end
        end
      endcase
    end
  end

  // Sequencing FSM: a memory wait parks the current state/count and restores them on ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state   <= RUN;
      count       <= 2'd0;
      saved_state <= RUN;
      saved_count <= 2'd0;
    end else begin
      case (cur_state)
        RUN: begin
          if (mem_stall) begin
            saved_state <= RUN;
            saved_count <= count;
            cur_state   <= MEM_WAIT;
          end else if (ex_redirect) begin
            if (FLUSH_CYCLES > 1) begin
              cur_state <= FLUSH;
              count     <= FLUSH_INIT;
            end
          end else if (hazard) begin
            if (LU_BUBBLES == 2) begin
              cur_state <= LU_STALL;
              count     <= 2'd1;
            end
          end
        end
        LU_STALL: begin
          if (mem_stall) begin
            saved_state <= LU_STALL;
            saved_count <= count;
            cur_state   <= MEM_WAIT;
          end else begin
            cur_state <= RUN;
            count     <= 2'd0;
          end
        end
        FLUSH: begin
          if (mem_stall) begin
            saved_state <= FLUSH;
            saved_count <= count;
            cur_state   <= MEM_WAIT;
          end else if (count <= 2'd1) begin
            cur_state <= RUN;
            count     <= 2'd0;
          end else begin
            count <= count - 2'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            cur_state <= saved_state;
            count     <= saved_count;
          end
        end
        default: begin
          cur_state <= RUN;
          count     <= 2'd0;
        end
      endcase
    end
  end

  // Saturating performance counters; a clear wins over any increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (pc_stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (redirect && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

endmodule
